btn_debounce_encoder: RTL and testbench

- Front-end stage that feeds the Simon game controller's player inputs, replacing the raw combinational button interpreter path.
- Synchronises and debounces the 4 raw push-buttons, then encodes a single accepted button into a 2-bit number.
- Produces a debounced hold level plus one-cycle press/release strobes.
- Rejects chords: two or more buttons down together are never accepted.

---
 rtl/btn_debounce_encoder.sv | 144 ++++++++++++++
 tb/tb_btn_debounce_encoder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_encoder.sv
//------------------------------------------------------------------------------
// Module   : btn_debounce_encoder
// Purpose  : Synchronises, debounces and encodes four raw push-buttons into a
//            2-bit index with hold level, press/release strobes and chord flag.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module btn_debounce_encoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btns,
  output logic [1:0] num,
  output logic       pressed,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       multi_err
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_DB_PRESS   = 2'd1,
    S_HELD       = 2'd2,
    S_DB_RELEASE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

  logic [3:0]       r_sync0;
  logic [3:0]       r_sync1;
  logic [3:0]       r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic             r_multi_prev;
  state_t           r_state;

  logic             w_nonzero;
  logic             w_onehot;
  logic             w_multi;
  logic             w_match;
  logic             w_last;
  logic [1:0]       w_enc;

  // Clearing the lowest set bit leaves zero only for a single-bit value.
  assign w_nonzero = (r_sync1 != 4'd0);
  assign w_onehot  = w_nonzero && ((r_sync1 & (r_sync1 - 4'd1)) == 4'd0);
  assign w_multi   = w_nonzero && !w_onehot;
  assign w_match   = (r_sync1 == r_cand);
  assign w_last    = (r_cnt == c_LAST);

  always_comb begin
    w_enc = 2'd0;
    case (r_cand)
      4'b0010: w_enc = 2'd1;
      4'b0100: w_enc = 2'd2;
      4'b1000: w_enc = 2'd3;
      default: w_enc = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync0 <= 4'd0;
      r_sync1 <= 4'd0;
    end else begin
      r_sync0 <= btns;
      r_sync1 <= r_sync0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_cand        <= 4'd0;
      r_multi_prev  <= 1'b0;
      num           <= 2'd0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      multi_err     <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      multi_err     <= 1'b0;
      r_multi_prev  <= w_multi;
      case (r_state)
        S_IDLE: begin
          if (w_onehot) begin
            r_cand  <= r_sync1;
            r_cnt   <= '0;
            r_state <= S_DB_PRESS;
          end else if (w_multi && !r_multi_prev) begin
            multi_err <= 1'b1;
          end
        end
        S_DB_PRESS: begin
          if (!w_match) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else if (w_last) begin
            r_cnt       <= '0;
            r_state     <= S_HELD;
            pressed     <= 1'b1;
            press_pulse <= 1'b1;
            num         <= w_enc;
          end else begin
            r_cnt <= r_cnt + c_ONE;
          end
        end
        S_HELD: begin
          if (!w_match) begin
            r_cnt   <= '0;
            r_state <= S_DB_RELEASE;
          end
        end
        S_DB_RELEASE: begin
          // Candidate reappearing before the count expires is a bounce.
          if (w_match) begin
            r_cnt   <= '0;
            r_state <= S_HELD;
          end else if (w_last) begin
            r_cnt         <= '0;
            r_state       <= S_IDLE;
            pressed       <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_ONE;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_btn_debounce_encoder.sv
// Testbench for btn_debounce_encoder: table vectors, latency sequences and a
// randomized run against a streak-timing reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_btn_debounce_encoder;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] btns = 4'd0;
  logic [1:0] num;
  logic       pressed;
  logic       press_pulse;
  logic       release_pulse;
  logic       multi_err;

  int total = 0;
  int bad   = 0;

  btn_debounce_encoder #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btns         (btns),
    .num          (num),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .multi_err    (multi_err)
  );

  always #5 clk = ~clk;

  // Reference model: a streak of identical observations that started at
  // edge t0 is accepted once D further edges have seen the same value.
  typedef struct packed {
    logic       pressed;
    logic       streak;
    logic       prev_multi;
    logic       pp;
    logic       rp;
    logic       me;
    logic [3:0] key;
    int         t0;
    logic [1:0] num;
  } mdl_t;

  mdl_t       m;
  int         n_edge;
  logic [3:0] h0;
  logic [3:0] h1;

  function automatic logic [1:0] idx_of(input logic [3:0] v);
    for (int i = 0; i < 4; i++)
      if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  function automatic mdl_t step(input mdl_t cur, input logic [3:0] s, input int n);
    mdl_t r    = cur;
    int   ones = $countones(s);
    r.pp = 1'b0;
    r.rp = 1'b0;
    r.me = !cur.pressed && !cur.streak && (ones >= 2) && !cur.prev_multi;
    r.prev_multi = (ones >= 2);
    if (!cur.pressed) begin
      if (!cur.streak) begin
        if (ones == 1) begin
          r.key = s; r.streak = 1'b1; r.t0 = n;
        end
      end else if (s != cur.key) begin
        r.streak = 1'b0;
      end else if (n - cur.t0 == D) begin
        r.pressed = 1'b1; r.pp = 1'b1; r.num = idx_of(cur.key); r.streak = 1'b0;
      end
    end else begin
      if (!cur.streak) begin
        if (s != cur.key) begin
          r.streak = 1'b1; r.t0 = n;
        end
      end else if (s == cur.key) begin
        r.streak = 1'b0;
      end else if (n - cur.t0 == D) begin
        r.pressed = 1'b0; r.rp = 1'b1; r.streak = 1'b0;
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m      <= '0;
      n_edge <= 0;
      h0     <= 4'd0;
      h1     <= 4'd0;
    end else begin
      m      <= step(m, h1, n_edge);
      n_edge <= n_edge + 1;
      h0     <= btns;
      h1     <= h0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick(input logic [3:0] b);
    btns = b;
    @(negedge clk);
    check("model", {26'd0, num, pressed, press_pulse, release_pulse, multi_err},
          {26'd0, m.num, m.pressed, m.pp, m.rp, m.me});
  endtask

  // Returns latency (edges after the first sampling edge) of the chosen strobe.
  task automatic measure(input logic [3:0] b, input bit want_press, input string name);
    int lat = -1;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      tick(b);
      if (want_press ? press_pulse : release_pulse) lat = i;
    end
    check(name, 32'(lat), 32'd6);
    tick(b);
    check({name, "_width"}, {31'd0, (want_press ? press_pulse : release_pulse)}, 32'd0);
  endtask

  typedef struct {
    logic [3:0] b;
    int         cyc;
    int         n_pp;
    int         n_rp;
    int         n_me;
    bit         end_pressed;
    logic [1:0] end_num;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int pp_n, rp_n, me_n;
    tbl.push_back('{4'b0000, 3, 0, 0, 0, 1'b0, 2'd0});
    tbl.push_back('{4'b0100, 8, 1, 0, 0, 1'b1, 2'd2});
    tbl.push_back('{4'b0100, 2, 0, 0, 0, 1'b1, 2'd2});
    tbl.push_back('{4'b0000, 8, 0, 1, 0, 1'b0, 2'd2});
    for (int r = 0; r < 5; r++) begin
      tbl.push_back('{4'b0001, 3, 0, 0, 0, 1'b0, 2'd2});
      tbl.push_back('{4'b0000, 1, 0, 0, 0, 1'b0, 2'd2});
    end
    tbl.push_back('{4'b0001, 8, 1, 0, 0, 1'b1, 2'd0});
    tbl.push_back('{4'b0000, 8, 0, 1, 0, 1'b0, 2'd0});
    tbl.push_back('{4'b0011, 20, 0, 0, 1, 1'b0, 2'd0});
    tbl.push_back('{4'b0010, 8, 1, 0, 0, 1'b1, 2'd1});
    tbl.push_back('{4'b0000, 8, 0, 1, 0, 1'b0, 2'd1});
    tbl.push_back('{4'b1000, 8, 1, 0, 0, 1'b1, 2'd3});
    tbl.push_back('{4'b0000, 2, 0, 0, 0, 1'b1, 2'd3});
    tbl.push_back('{4'b1000, 6, 0, 0, 0, 1'b1, 2'd3});
    tbl.push_back('{4'b0000, 8, 0, 1, 0, 1'b0, 2'd3});
    tbl.push_back('{4'b0001, 8, 1, 0, 0, 1'b1, 2'd0});
    tbl.push_back('{4'b0010, 8, 0, 1, 0, 1'b0, 2'd0});
    tbl.push_back('{4'b0010, 8, 1, 0, 0, 1'b1, 2'd1});
    tbl.push_back('{4'b0000, 8, 0, 1, 0, 1'b0, 2'd1});

    #2;
    check("reset_outputs", {26'd0, num, pressed, press_pulse, release_pulse, multi_err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[v]) begin
      pp_n = 0; rp_n = 0; me_n = 0;
      for (int c = 0; c < tbl[v].cyc; c++) begin
        tick(tbl[v].b);
        pp_n += int'(press_pulse);
        rp_n += int'(release_pulse);
        me_n += int'(multi_err);
      end
      check($sformatf("vec%0d", v),
            {pp_n[7:0], rp_n[7:0], me_n[7:0], 5'd0, pressed, num},
            {tbl[v].n_pp[7:0], tbl[v].n_rp[7:0], tbl[v].n_me[7:0], 5'd0,
             tbl[v].end_pressed, tbl[v].end_num});
    end

    measure(4'b0100, 1'b1, "press_latency");
    check("press_num", {30'd0, num}, 32'd2);
    measure(4'b0000, 1'b0, "release_latency");
    check("release_num_hold", {30'd0, num, pressed}, {30'd0, 2'd2, 1'b0});

    for (int c = 0; c < 10; c++) tick(4'b0100);
    check("held_before_reset", {31'd0, pressed}, 32'd1);
    #2 reset = 1'b0;
    #1 check("async_reset_clear", {26'd0, num, pressed, press_pulse, release_pulse, multi_err}, 32'd0);
    @(negedge clk);
    #1 reset = 1'b1;
    measure(4'b0100, 1'b1, "post_reset_latency");
    check("post_reset_num", {30'd0, num}, 32'd2);

    for (int blk = 0; blk < 150; blk++) begin
      logic [3:0] b;
      int         r;
      int         hold;
      r = $urandom_range(0, 9);
      if (r < 2)      b = 4'd0;
      else if (r < 8) b = 4'b0001 << $urandom_range(0, 3);
      else            b = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 12);
      for (int c = 0; c < hold; c++) tick(b);
    end
    for (int c = 0; c < 10; c++) tick(4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

`default_nettype wire
